alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 140 ++++++++++++++
 tb/tb_alu_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational 8-bit ALU between two requesters.
// Round-robin grant in IDLE, operands held on the ALU for ALU_WAIT cycles,
// result held in RESP until the consumer takes it.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no operation in flight; one valid requester may be granted
// EXEC  | operands driven to the ALU; wait_cnt counts down to capture
// RESP  | rsp_data/rsp_id held with rsp_valid until rsp_ready
module alu_arbiter #(
    parameter int ALU_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_opcode,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_opcode,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_zout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_data,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // ALU_WAIT is limited to 1..4, so the countdown fits in two bits.
    localparam logic [1:0] WAIT_INIT = 2'(ALU_WAIT - 1);

    state_t     state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [3:0] alu_opcode_q, alu_opcode_d;
    logic [7:0] alu_a_q, alu_a_d;
    logic [7:0] alu_b_q, alu_b_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_id_q, rsp_id_d;

    logic       grant0, grant1;
    logic       ready0, ready1;

    // Round-robin pick: on contention the requester not granted last wins.
    assign grant0 = req0_valid & (~req1_valid | last_grant_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_grant_q);

    // Next-state and handshake logic; ready is forced low while reset is high.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        alu_opcode_d = alu_opcode_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        ready0       = 1'b0;
        ready1       = 1'b0;

        case (state_q)
            IDLE: begin
                ready0 = grant0 & ~reset;
                ready1 = grant1 & ~reset;
                if (ready0 || ready1) begin
                    alu_opcode_d = ready1 ? req1_opcode : req0_opcode;
                    alu_a_d      = ready1 ? req1_a      : req0_a;
                    alu_b_d      = ready1 ? req1_b      : req0_b;
                    rsp_id_d     = ready1;
                    last_grant_d = ready1;
                    wait_cnt_d   = WAIT_INIT;
                    state_d      = EXEC;
                end
            end
            EXEC: begin
                if (wait_cnt_q == 2'd0) begin
                    rsp_data_d = alu_zout;
                    state_d    = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= 2'd0;
            alu_opcode_q <= 4'd0;
            alu_a_q      <= 8'd0;
            alu_b_q      <= 8'd0;
            rsp_data_q   <= 8'd0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
            alu_opcode_q <= alu_opcode_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    assign req0_ready = ready0;
    assign req1_ready = ready1;
    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_valid  = (state_q == RESP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two DUT instances (ALU_WAIT=1 and ALU_WAIT=4) driven by
// directed scenarios followed by randomized traffic checked against a
// transaction-level timing model.
module tb_alu_arbiter;

    localparam int W0 = 1;
    localparam int W1 = 4;

    logic       clk;
    logic       reset       [2];
    logic       req0_valid  [2];
    logic       req0_ready  [2];
    logic [3:0] req0_opcode [2];
    logic [7:0] req0_a      [2];
    logic [7:0] req0_b      [2];
    logic       req1_valid  [2];
    logic       req1_ready  [2];
    logic [3:0] req1_opcode [2];
    logic [7:0] req1_a      [2];
    logic [7:0] req1_b      [2];
    logic [3:0] alu_opcode  [2];
    logic [7:0] alu_a       [2];
    logic [7:0] alu_b       [2];
    logic [7:0] alu_zout    [2];
    logic       rsp_valid   [2];
    logic       rsp_ready   [2];
    logic       rsp_id      [2];
    logic [7:0] rsp_data    [2];
    logic       busy        [2];

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural ALU: 6=AND, 8=OR, 10=XOR, others arbitrary but fixed.
    function automatic logic [7:0] alu_fn(logic [3:0] op, logic [7:0] a, logic [7:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a;
            4'd3:    return b;
            4'd4:    return ~a;
            4'd5:    return {a[6:0], 1'b0};
            4'd6:    return a & b;
            4'd7:    return ~(a & b);
            4'd8:    return a | b;
            4'd9:    return ~(a | b);
            4'd10:   return a ^ b;
            4'd11:   return ~(a ^ b);
            4'd12:   return {1'b0, a[7:1]};
            4'd13:   return a + 8'd1;
            4'd14:   return a - 8'd1;
            default: return b - a;
        endcase
    endfunction

    function automatic int wait_of(int k);
        return (k == 0) ? W0 : W1;
    endfunction

    assign alu_zout[0] = alu_fn(alu_opcode[0], alu_a[0], alu_b[0]);
    assign alu_zout[1] = alu_fn(alu_opcode[1], alu_a[1], alu_b[1]);

    alu_arbiter #(.ALU_WAIT(W0)) u_w1 (
        .clk(clk), .reset(reset[0]),
        .req0_valid(req0_valid[0]), .req0_ready(req0_ready[0]),
        .req0_opcode(req0_opcode[0]), .req0_a(req0_a[0]), .req0_b(req0_b[0]),
        .req1_valid(req1_valid[0]), .req1_ready(req1_ready[0]),
        .req1_opcode(req1_opcode[0]), .req1_a(req1_a[0]), .req1_b(req1_b[0]),
        .alu_opcode(alu_opcode[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]),
        .alu_zout(alu_zout[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_id(rsp_id[0]), .rsp_data(rsp_data[0]), .busy(busy[0])
    );

    alu_arbiter #(.ALU_WAIT(W1)) u_w4 (
        .clk(clk), .reset(reset[1]),
        .req0_valid(req0_valid[1]), .req0_ready(req0_ready[1]),
        .req0_opcode(req0_opcode[1]), .req0_a(req0_a[1]), .req0_b(req0_b[1]),
        .req1_valid(req1_valid[1]), .req1_ready(req1_ready[1]),
        .req1_opcode(req1_opcode[1]), .req1_a(req1_a[1]), .req1_b(req1_b[1]),
        .alu_opcode(alu_opcode[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]),
        .alu_zout(alu_zout[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_id(rsp_id[1]), .rsp_data(rsp_data[1]), .busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s [inst %0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic quiet(int k);
        req0_valid[k]  = 1'b0;
        req0_opcode[k] = 4'd0;
        req0_a[k]      = 8'd0;
        req0_b[k]      = 8'd0;
        req1_valid[k]  = 1'b0;
        req1_opcode[k] = 4'd0;
        req1_a[k]      = 8'd0;
        req1_b[k]      = 8'd0;
        rsp_ready[k]   = 1'b0;
    endtask

    task automatic set_req(int k, int r, logic [3:0] op, logic [7:0] a, logic [7:0] b);
        if (r == 0) begin
            req0_valid[k] = 1'b1; req0_opcode[k] = op; req0_a[k] = a; req0_b[k] = b;
        end else begin
            req1_valid[k] = 1'b1; req1_opcode[k] = op; req1_a[k] = a; req1_b[k] = b;
        end
    endtask

    task automatic do_reset(int k);
        to_drive();
        quiet(k);
        reset[k] = 1'b1;
        to_sample();
        to_drive();
        reset[k] = 1'b0;
        to_sample();
    endtask

    // Counts sample points after the grant cycle until rsp_valid is seen (bounded).
    task automatic wait_rsp(int k, bit drop, output int lat);
        lat = 0;
        repeat (20) begin
            to_drive();
            if (drop) begin
                req0_valid[k] = 1'b0;
                req1_valid[k] = 1'b0;
            end
            to_sample();
            lat++;
            if (rsp_valid[k]) break;
        end
    endtask

    task automatic chk_all_zero(string tag, int k);
        chk({tag, "_opcode"}, k, 32'(alu_opcode[k]), 32'd0);
        chk({tag, "_alu_a"},  k, 32'(alu_a[k]),      32'd0);
        chk({tag, "_alu_b"},  k, 32'(alu_b[k]),      32'd0);
        chk({tag, "_data"},   k, 32'(rsp_data[k]),   32'd0);
        chk({tag, "_id"},     k, 32'(rsp_id[k]),     32'd0);
        chk({tag, "_rvalid"}, k, 32'(rsp_valid[k]),  32'd0);
        chk({tag, "_busy"},   k, 32'(busy[k]),       32'd0);
        chk({tag, "_rdy0"},   k, 32'(req0_ready[k]), 32'd0);
        chk({tag, "_rdy1"},   k, 32'(req1_ready[k]), 32'd0);
    endtask

    // Random traffic against a timing model: a grant in cycle g owes a response
    // from cycle g+ALU_WAIT+1 on, with nothing else accepted until it is taken.
    task automatic rand_run(int k, int ncyc);
        bit         pend  = 1'b0;
        bit         mlast = 1'b1;
        bit         mid   = 1'b0;
        bit         e0, e1;
        int         due   = 0;
        logic [3:0] mop   = 4'd0;
        logic [7:0] ma    = 8'd0;
        logic [7:0] mb    = 8'd0;
        do_reset(k);
        for (int c = 0; c < ncyc; c++) begin
            to_drive();
            req0_valid[k]  = ($urandom_range(0, 2) != 0);
            req0_opcode[k] = 4'($urandom_range(0, 15));
            req0_a[k]      = 8'($urandom);
            req0_b[k]      = 8'($urandom);
            req1_valid[k]  = ($urandom_range(0, 2) != 0);
            req1_opcode[k] = 4'($urandom_range(0, 15));
            req1_a[k]      = 8'($urandom);
            req1_b[k]      = 8'($urandom);
            rsp_ready[k]   = ($urandom_range(0, 1) != 0);
            to_sample();
            if (!pend) begin
                e0 = req0_valid[k] && (!req1_valid[k] || mlast);
                e1 = req1_valid[k] && (!req0_valid[k] || !mlast);
                chk("rnd_rdy0_idle", k, 32'(req0_ready[k]), 32'(e0));
                chk("rnd_rdy1_idle", k, 32'(req1_ready[k]), 32'(e1));
                chk("rnd_busy_idle", k, 32'(busy[k]),       32'd0);
                chk("rnd_rv_idle",   k, 32'(rsp_valid[k]),  32'd0);
                if (e0 || e1) begin
                    pend  = 1'b1;
                    mid   = e1;
                    mop   = e1 ? req1_opcode[k] : req0_opcode[k];
                    ma    = e1 ? req1_a[k]      : req0_a[k];
                    mb    = e1 ? req1_b[k]      : req0_b[k];
                    due   = c + wait_of(k) + 1;
                    mlast = e1;
                end
            end else begin
                chk("rnd_rdy0_busy", k, 32'(req0_ready[k]), 32'd0);
                chk("rnd_rdy1_busy", k, 32'(req1_ready[k]), 32'd0);
                chk("rnd_busy",      k, 32'(busy[k]),       32'd1);
                chk("rnd_alu_op",    k, 32'(alu_opcode[k]), 32'(mop));
                chk("rnd_alu_a",     k, 32'(alu_a[k]),      32'(ma));
                chk("rnd_alu_b",     k, 32'(alu_b[k]),      32'(mb));
                chk("rnd_rvalid",    k, 32'(rsp_valid[k]),  32'(c >= due));
                if (c >= due) begin
                    chk("rnd_rdata", k, 32'(rsp_data[k]), 32'(alu_fn(mop, ma, mb)));
                    chk("rnd_rid",   k, 32'(rsp_id[k]),   32'(mid));
                    if (rsp_ready[k]) pend = 1'b0;
                end
            end
        end
        to_drive();
        quiet(k);
        to_sample();
    endtask

    initial begin
        int         lat;
        int         ng;
        int         n_stable;
        int         g [3];
        logic [7:0] last_z;

        // Reset: readies must stay low while reset is high, then all outputs clear.
        for (int k = 0; k < 2; k++) begin
            quiet(k);
            reset[k]      = 1'b1;
            req0_valid[k] = 1'b1;
            req1_valid[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rdy0_hi", k, 32'(req0_ready[k]), 32'd0);
            chk("rst_rdy1_hi", k, 32'(req1_ready[k]), 32'd0);
        end
        to_drive();
        for (int k = 0; k < 2; k++) begin
            quiet(k);
            reset[k] = 1'b0;
        end
        to_sample();
        for (int k = 0; k < 2; k++) chk_all_zero("rst", k);

        // Single req0 AND: response two cycles after the grant cycle.
        to_drive();
        set_req(0, 0, 4'd6, 8'hF0, 8'h3C);
        rsp_ready[0] = 1'b1;
        to_sample();
        chk("and_rdy0", 0, 32'(req0_ready[0]), 32'd1);
        chk("and_rdy1", 0, 32'(req1_ready[0]), 32'd0);
        wait_rsp(0, 1'b1, lat);
        chk("and_latency", 0, 32'(lat), 32'(W0 + 1));
        chk("and_data", 0, 32'(rsp_data[0]), 32'h30);
        chk("and_id",   0, 32'(rsp_id[0]),   32'd0);
        to_drive();
        to_sample();
        chk("and_rv_fall", 0, 32'(rsp_valid[0]), 32'd0);
        chk("and_idle",    0, 32'(busy[0]),      32'd0);

        // Contention after reset: req0 first, then req1 by round robin.
        do_reset(0);
        to_drive();
        set_req(0, 0, 4'd8,  8'h0F, 8'hF0);
        set_req(0, 1, 4'd10, 8'hFF, 8'h0F);
        rsp_ready[0] = 1'b1;
        to_sample();
        chk("rr1_rdy0", 0, 32'(req0_ready[0]), 32'd1);
        chk("rr1_rdy1", 0, 32'(req1_ready[0]), 32'd0);
        wait_rsp(0, 1'b0, lat);
        chk("rr1_latency", 0, 32'(lat), 32'(W0 + 1));
        chk("rr1_id",   0, 32'(rsp_id[0]),   32'd0);
        chk("rr1_data", 0, 32'(rsp_data[0]), 32'hFF);
        to_drive();
        to_sample();
        chk("rr2_rdy0", 0, 32'(req0_ready[0]), 32'd0);
        chk("rr2_rdy1", 0, 32'(req1_ready[0]), 32'd1);
        wait_rsp(0, 1'b1, lat);
        chk("rr2_latency", 0, 32'(lat), 32'(W0 + 1));
        chk("rr2_id",   0, 32'(rsp_id[0]),   32'd1);
        chk("rr2_data", 0, 32'(rsp_data[0]), 32'hF0);
        to_drive();
        to_sample();
        chk("rr2_idle", 0, 32'(busy[0]), 32'd0);

        // Response stall: everything holds while rsp_ready is low.
        to_drive();
        set_req(0, 0, 4'd0, 8'h12, 8'h34);
        rsp_ready[0] = 1'b0;
        to_sample();
        chk("stall_grant", 0, 32'(req0_ready[0]), 32'd1);
        wait_rsp(0, 1'b1, lat);
        chk("stall_latency", 0, 32'(lat), 32'(W0 + 1));
        for (int i = 0; i < 5; i++) begin
            to_drive();
            set_req(0, 0, 4'd3, 8'($urandom), 8'($urandom));
            set_req(0, 1, 4'd4, 8'($urandom), 8'($urandom));
            to_sample();
            chk("stall_rvalid", 0, 32'(rsp_valid[0]),  32'd1);
            chk("stall_data",   0, 32'(rsp_data[0]),   32'h46);
            chk("stall_id",     0, 32'(rsp_id[0]),     32'd0);
            chk("stall_rdy0",   0, 32'(req0_ready[0]), 32'd0);
            chk("stall_rdy1",   0, 32'(req1_ready[0]), 32'd0);
            chk("stall_busy",   0, 32'(busy[0]),       32'd1);
        end
        to_drive();
        quiet(0);
        rsp_ready[0] = 1'b1;
        to_sample();
        chk("stall_hs_rv", 0, 32'(rsp_valid[0]), 32'd1);
        to_drive();
        to_sample();
        chk("stall_rv_fall", 0, 32'(rsp_valid[0]), 32'd0);

        // Reset during EXEC (last grant was req0): no response, outputs clear,
        // and req0 still wins the next contention.
        to_drive();
        set_req(0, 0, 4'd11, 8'hA5, 8'h5A);
        rsp_ready[0] = 1'b1;
        to_sample();
        chk("rexec_grant", 0, 32'(req0_ready[0]), 32'd1);
        to_drive();
        quiet(0);
        rsp_ready[0] = 1'b1;
        reset[0]     = 1'b1;
        to_sample();
        chk("rexec_in_exec", 0, 32'(busy[0]), 32'd1);
        to_drive();
        reset[0] = 1'b0;
        to_sample();
        chk_all_zero("rexec", 0);
        for (int i = 0; i < 4; i++) begin
            to_drive();
            to_sample();
            chk("rexec_no_rsp", 0, 32'(rsp_valid[0]), 32'd0);
        end
        to_drive();
        set_req(0, 0, 4'd2, 8'h11, 8'h22);
        set_req(0, 1, 4'd3, 8'h33, 8'h44);
        to_sample();
        chk("rexec_rdy0", 0, 32'(req0_ready[0]), 32'd1);
        chk("rexec_rdy1", 0, 32'(req1_ready[0]), 32'd0);
        wait_rsp(0, 1'b1, lat);
        chk("rexec_data", 0, 32'(rsp_data[0]), 32'h11);
        to_drive();
        quiet(0);
        to_sample();

        // ALU_WAIT=4: operands held four EXEC cycles, capture of the last one.
        do_reset(1);
        to_drive();
        set_req(1, 0, 4'd1, 8'h5A, 8'hC3);
        rsp_ready[1] = 1'b1;
        to_sample();
        chk("w4_grant", 1, 32'(req0_ready[1]), 32'd1);
        lat      = 0;
        n_stable = 0;
        last_z   = 8'd0;
        repeat (20) begin
            to_drive();
            req0_valid[1] = 1'b0;
            req0_a[1]     = 8'($urandom);
            req0_b[1]     = 8'($urandom);
            set_req(1, 1, 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            to_sample();
            lat++;
            if (rsp_valid[1]) break;
            chk("w4_hold_op", 1, 32'(alu_opcode[1]), 32'd1);
            chk("w4_hold_a",  1, 32'(alu_a[1]),      32'h5A);
            chk("w4_hold_b",  1, 32'(alu_b[1]),      32'hC3);
            chk("w4_rdy1",    1, 32'(req1_ready[1]), 32'd0);
            last_z = alu_zout[1];
            n_stable++;
        end
        chk("w4_exec_cycles", 1, 32'(n_stable), 32'd4);
        chk("w4_latency",     1, 32'(lat), 32'(W1 + 1));
        chk("w4_capture",     1, 32'(rsp_data[1]), 32'(last_z));
        chk("w4_data",        1, 32'(rsp_data[1]), 32'h97);
        to_drive();
        quiet(1);
        to_sample();
        chk("w4_idle", 1, 32'(busy[1]), 32'd0);

        // Lone req1 held valid: back-to-back grants every ALU_WAIT+2 cycles.
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            ng = 0;
            g  = '{0, 0, 0};
            to_drive();
            set_req(k, 1, 4'd13, 8'($urandom), 8'($urandom));
            rsp_ready[k] = 1'b1;
            for (int c = 0; c < 60; c++) begin
                to_sample();
                if (req1_ready[k]) begin
                    g[ng] = c;
                    ng++;
                end
                if (ng >= 3) break;
                to_drive();
                req1_a[k] = 8'($urandom);
            end
            chk("b2b_count", k, 32'(ng), 32'd3);
            chk("b2b_gap1",  k, 32'(g[1] - g[0]), 32'(wait_of(k) + 2));
            chk("b2b_gap2",  k, 32'(g[2] - g[1]), 32'(wait_of(k) + 2));
            to_drive();
            quiet(k);
            to_sample();
        end

        // Randomized traffic on both instances.
        rand_run(0, 400);
        rand_run(1, 400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
